// File: rtl/frame_deframer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | frame_deframer: hunts SYNC, parses len/payload/checksum frames,       |
// | emits payload with first/last markers and per-frame verdicts.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module frame_deframer #(
   parameter int              BITS    = 8,
   parameter logic [BITS-1:0] SYNC    = 'hA5,
   parameter int              MAX_LEN = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inValid,
   input  logic [BITS-1:0] inData,
   output logic            outValid,
   output logic [BITS-1:0] outData,
   output logic            outFirst,
   output logic            outLast,
   output logic            frameOk,
   output logic            frameErr,
   output logic [7:0]      goodCount,
   output logic [7:0]      errCount
);

   localparam logic [BITS-1:0] c_max_len = BITS'(MAX_LEN);

   typedef enum logic [1:0] {
      S_HUNT = 2'd0,
      S_LEN  = 2'd1,
      S_PAY  = 2'd2,
      S_CHK  = 2'd3
   } state_t;

   state_t          r_state, w_state;
   logic [BITS-1:0] r_rem, w_rem;
   logic [BITS-1:0] r_sum, w_sum;
   logic            r_first, w_first;
   logic            r_out_valid, w_out_valid;
   logic [BITS-1:0] r_out_data, w_out_data;
   logic            r_out_first, w_out_first;
   logic            r_out_last, w_out_last;
   logic            r_ok, w_ok;
   logic            r_err, w_err;
   logic [7:0]      r_good, w_good;
   logic [7:0]      r_errc, w_errc;
   logic [7:0]      w_good_inc, w_errc_inc;

   assign w_good_inc = (r_good == 8'hFF) ? r_good : r_good + 8'd1;
   assign w_errc_inc = (r_errc == 8'hFF) ? r_errc : r_errc + 8'd1;

   always_comb begin
      w_state     = r_state;
      w_rem       = r_rem;
      w_sum       = r_sum;
      w_first     = r_first;
      w_out_valid = 1'b0;
      w_out_data  = r_out_data;
      w_out_first = 1'b0;
      w_out_last  = 1'b0;
      w_ok        = 1'b0;
      w_err       = 1'b0;
      w_good      = r_good;
      w_errc      = r_errc;
      if (inValid) begin
         case (r_state)
            S_HUNT: begin
               if (inData == SYNC) w_state = S_LEN;
            end
            S_LEN: begin
               // A SYNC value here is a length, never a resync.
               if ((inData == '0) || (inData > c_max_len)) begin
                  w_state = S_HUNT;
                  w_err   = 1'b1;
                  w_errc  = w_errc_inc;
               end else begin
                  w_rem   = inData;
                  w_sum   = inData;
                  w_first = 1'b1;
                  w_state = S_PAY;
               end
            end
            S_PAY: begin
               w_out_valid = 1'b1;
               w_out_data  = inData;
               w_out_first = r_first;
               w_first     = 1'b0;
               w_sum       = r_sum + inData;
               w_rem       = r_rem - BITS'(1);
               if (r_rem == BITS'(1)) begin
                  w_out_last = 1'b1;
                  w_state    = S_CHK;
               end
            end
            S_CHK: begin
               if (inData == r_sum) begin
                  w_ok   = 1'b1;
                  w_good = w_good_inc;
               end else begin
                  w_err  = 1'b1;
                  w_errc = w_errc_inc;
               end
               w_state = S_HUNT;
            end
            default: w_state = S_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_HUNT;
         r_rem       <= '0;
         r_sum       <= '0;
         r_first     <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_first <= 1'b0;
         r_out_last  <= 1'b0;
         r_ok        <= 1'b0;
         r_err       <= 1'b0;
         r_good      <= 8'd0;
         r_errc      <= 8'd0;
      end else begin
         r_state     <= w_state;
         r_rem       <= w_rem;
         r_sum       <= w_sum;
         r_first     <= w_first;
         r_out_valid <= w_out_valid;
         r_out_data  <= w_out_data;
         r_out_first <= w_out_first;
         r_out_last  <= w_out_last;
         r_ok        <= w_ok;
         r_err       <= w_err;
         r_good      <= w_good;
         r_errc      <= w_errc;
      end
   end

   assign outValid  = r_out_valid;
   assign outData   = r_out_data;
   assign outFirst  = r_out_first;
   assign outLast   = r_out_last;
   assign frameOk   = r_ok;
   assign frameErr  = r_err;
   assign goodCount = r_good;
   assign errCount  = r_errc;

endmodule
`default_nettype wire
